// File: rtl/im_fetch_param.sv
// Instruction memory with a program-load write port and a one-entry fetch register.
// A fetch returns one word or an address-wrapping pair of words, one cycle after it is accepted.
module im_fetch_param #(
  parameter int              XLEN     = 32,
  parameter int              ADDR_W   = 6,
  parameter logic [XLEN-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_pc,
  input  logic                fetch_pair,
  output logic                fetch_ready,
  output logic                ir_valid,
  input  logic                ir_ready,
  output logic [2*XLEN-1:0]   ir,
  output logic [ADDR_W-1:0]   ir_pc,
  output logic [ADDR_W:0]     load_count
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

  logic [XLEN-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [ADDR_W-1:0] pc_next;
  logic [XLEN-1:0]   word_a;
  logic [XLEN-1:0]   word_b;
  logic              accept;

  // Handshake: a fetch transfers on a rising edge where fetch_req && fetch_ready;
  // a result transfers on a rising edge where ir_valid && ir_ready. While ir_valid
  // is high and ir_ready low, ir/ir_pc/ir_valid hold and fetch_ready is low.
  assign fetch_ready = !ir_valid || ir_ready;
  assign accept      = fetch_req && fetch_ready;
  assign pc_next     = fetch_pc + ADDR_W'(1);

  // Write-first forwarding; written bits make stale contents read as NOP_WORD.
  assign word_a = (wr_en && (wr_addr == fetch_pc)) ? wr_data :
                  (written[fetch_pc] ? mem[fetch_pc] : NOP_WORD);
  assign word_b = (wr_en && (wr_addr == pc_next)) ? wr_data :
                  (written[pc_next] ? mem[pc_next] : NOP_WORD);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      written    <= '0;
      load_count <= '0;
    end else if (wr_en) begin
      written[wr_addr] <= 1'b1;
      if (!written[wr_addr] && (load_count != FULL))
        load_count <= load_count + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
    end else if (accept) begin
      ir_valid <= 1'b1;
      ir       <= {word_a, (fetch_pair ? word_b : {XLEN{1'b0}})};
      ir_pc    <= fetch_pc;
    end else if (ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_im_fetch_param.sv
// Directed bench for im_fetch_param: the driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares each result as it is handed over.
module tb_im_fetch_param;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 6;
  localparam int EW     = 2*XLEN + ADDR_W;

  logic                clk;
  logic                reset;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                fetch_req;
  logic [ADDR_W-1:0]   fetch_pc;
  logic                fetch_pair;
  logic                fetch_ready;
  logic                ir_valid;
  logic                ir_ready;
  logic [2*XLEN-1:0]   ir;
  logic [ADDR_W-1:0]   ir_pc;
  logic [ADDR_W:0]     load_count;

  logic [EW-1:0] exp_q[$];
  int vectors;
  int miscompares;

  im_fetch_param #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NOP_WORD(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_pair(fetch_pair),
    .fetch_ready(fetch_ready), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir(ir), .ir_pc(ir_pc), .load_count(load_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo, input logic [ADDR_W-1:0] pc);
    exp_q.push_back({hi, lo, pc});
  endtask

  // one clock cycle of stimulus; inputs return to idle #1 after the edge
  task automatic step(input bit we, input logic [ADDR_W-1:0] wa, input logic [XLEN-1:0] wd,
                      input bit fr, input logic [ADDR_W-1:0] pc, input bit pr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    fetch_req = fr; fetch_pc = pc; fetch_pair = pr;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    fetch_req = 1'b0;
  endtask

  task automatic write(input logic [ADDR_W-1:0] wa, input logic [XLEN-1:0] wd);
    step(1'b1, wa, wd, 1'b0, '0, 1'b0);
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] pc, input bit pr);
    step(1'b0, '0, '0, 1'b1, pc, pr);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // scoreboard monitor: a result is handed over at the next edge
  always @(negedge clk) begin
    if (reset && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %h expected none", {ir, ir_pc});
      end else begin
        check("ir_result", {ir, ir_pc}, exp_q.pop_front());
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    fetch_req = 1'b0; fetch_pc = '0; fetch_pair = 1'b0;
    ir_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ir_valid", EW'(ir_valid), EW'(0));
    check("rst_ir", EW'(ir), EW'(0));
    check("rst_load_count", EW'(load_count), EW'(0));
    check("rst_fetch_ready", EW'(fetch_ready), EW'(1));
    reset = 1'b1;

    // basic load and pair fetch
    write(6'd0, 32'h11); write(6'd1, 32'h22); write(6'd2, 32'h33); write(6'd3, 32'h44);
    push(32'h33, 32'h44, 6'd2);
    fetch(6'd2, 1'b1);
    check("pair_ir_pc", EW'(ir_pc), EW'(2));
    check("pair_load_count", EW'(load_count), EW'(4));

    // wrap-around, then back-to-back with forwarding into the lower half
    write(6'd63, 32'hAA); write(6'd0, 32'hBB);
    push(32'hAA, 32'hBB, 6'd63);
    fetch(6'd63, 1'b1);
    push(32'hAA, 32'hCC, 6'd63);
    step(1'b1, 6'd0, 32'hCC, 1'b1, 6'd63, 1'b1);
    check("rewrite_load_count", EW'(load_count), EW'(5));

    // unwritten word, then same-cycle write plus fetch
    push(32'h13, 32'h0, 6'd5);
    fetch(6'd5, 1'b0);
    push(32'h77, 32'h0, 6'd5);
    step(1'b1, 6'd5, 32'h77, 1'b1, 6'd5, 1'b0);
    check("fwd_load_count", EW'(load_count), EW'(6));
    idle();

    // hold: result must survive rewrites of its word and refuse new fetches
    ir_ready = 1'b0;
    push(32'h22, 32'h0, 6'd1);
    fetch(6'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("hold_fetch_ready", EW'(fetch_ready), EW'(0));
      check("hold_ir", EW'(ir), {6'd0, 32'h22, 32'h0});
      step(1'b1, 6'd1, 32'h99, 1'b1, 6'd3, 1'b1);
    end
    ir_ready = 1'b1;
    push(32'h33, 32'h44, 6'd2);
    fetch(6'd2, 1'b1);
    check("release_ir_pc", EW'(ir_pc), EW'(2));
    check("release_ir_valid", EW'(ir_valid), EW'(1));
    idle();
    push(32'h99, 32'h33, 6'd1);
    fetch(6'd1, 1'b1);
    idle();

    // reset asserted mid-hold, between edges
    ir_ready = 1'b0;
    fetch(6'd2, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_ir_valid", EW'(ir_valid), EW'(0));
    check("async_load_count", EW'(load_count), EW'(0));
    check("async_ir", EW'({ir, ir_pc}), EW'(0));
    exp_q.delete();
    ir_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h55;
    fetch_req = 1'b1; fetch_pc = 6'd9; fetch_pair = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b0;
    fetch_req = 1'b0;
    check("inrst_ir_valid", EW'(ir_valid), EW'(0));
    reset = 1'b1;
    check("post_rst_load_count", EW'(load_count), EW'(0));
    push(32'h13, 32'h0, 6'd2);
    fetch(6'd2, 1'b0);
    push(32'h13, 32'h13, 6'd9);
    fetch(6'd9, 1'b1);

    // load_count counts distinct words and saturates at DEPTH
    write(6'd7, 32'h1); write(6'd7, 32'h2); write(6'd8, 32'h3);
    check("distinct_load_count", EW'(load_count), EW'(2));
    for (int i = 0; i < 64; i++) write(6'(i), 32'h100 + 32'(i));
    write(6'd10, 32'hDEAD);
    check("full_load_count", EW'(load_count), EW'(64));
    push(32'h13F, 32'h100, 6'd63);
    fetch(6'd63, 1'b1);
    push(32'hDEAD, 32'h10B, 6'd10);
    fetch(6'd10, 1'b1);

    repeat (3) idle();
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
